// File: rtl/divider_32bit.sv
// divider_32bit: iterative restoring divide/remainder unit for RV32M DIV, DIVU, REM and REMU
module divider_32bit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [1:0]      div_op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, next_state;
    logic [1:0] op;
    logic [XLEN-1:0] rem, quot, dvs, result;
    logic [CW-1:0] cnt;
    logic neg_quot, neg_rem;
    logic sgn, a_neg, b_neg, div_zero, ovf, special, accept, last, ge;
    logic [XLEN-1:0] a_mag, b_mag, special_res, rem_nx, quot_nx, final_res;
    logic [XLEN:0] shifted;
    assign sgn = ~div_op_i[0];
    assign a_neg = sgn & operand_a_i[XLEN-1];
    assign b_neg = sgn & operand_b_i[XLEN-1];
    assign a_mag = a_neg ? -operand_a_i : operand_a_i;
    assign b_mag = b_neg ? -operand_b_i : operand_b_i;
    assign div_zero = operand_b_i == '0;
    assign ovf = sgn && operand_a_i == {1'b1, {(XLEN-1){1'b0}}} && operand_b_i == '1;
    assign special = div_zero | ovf;
    // overflow DIV returns the dividend itself (the most negative value)
    assign special_res = div_zero ? (div_op_i[1] ? operand_a_i : '1) : (div_op_i[1] ? '0 : operand_a_i);
    assign accept = state == IDLE && start_i && !kill_i;
    assign last = cnt == CW'(XLEN-1);
    assign shifted = {rem, quot[XLEN-1]};
    assign ge = shifted >= {1'b0, dvs};
    assign rem_nx = ge ? shifted[XLEN-1:0] - dvs : shifted[XLEN-1:0];
    assign quot_nx = {quot[XLEN-2:0], ge};
    assign final_res = op[1] ? (neg_rem ? -rem_nx : rem_nx) : (neg_quot ? -quot_nx : quot_nx);
    assign busy_o = state != IDLE;
    assign valid_o = state == DONE && !kill_i;
    assign result_o = result;
    always_comb begin
        next_state = state;
        if (kill_i) next_state = IDLE;
        else if (state == IDLE && start_i) next_state = special ? DONE : CALC;
        else if (state == CALC && last) next_state = DONE;
        else if (state == DONE) next_state = IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else state <= next_state;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op <= '0;
            rem <= '0;
            quot <= '0;
            dvs <= '0;
            cnt <= '0;
            neg_quot <= 1'b0;
            neg_rem <= 1'b0;
            result <= '0;
        end else if (accept) begin
            op <= div_op_i;
            rem <= '0;
            quot <= a_mag;
            dvs <= b_mag;
            cnt <= '0;
            neg_quot <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (special) result <= special_res;
        end else if (state == CALC) begin
            rem <= rem_nx;
            quot <= quot_nx;
            cnt <= cnt + 1'b1;
            if (last && !kill_i) result <= final_res;
        end
    end
endmodule

// File: tb/tb_divider_32bit.sv
// tb_divider_32bit: vector table plus scoreboard bench for divider_32bit
module tb_divider_32bit;
    logic clk = 1'b0;
    logic rst_ni, start_i, kill_i;
    logic [1:0] div_op_i;
    logic [31:0] a, b, result_o;
    logic busy_o, valid_o;
    int total = 0;
    int bad = 0;
    logic [31:0] sb[$];
    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;
    vec_t vecs[22];

    divider_32bit #(.XLEN(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .kill_i(kill_i),
        .div_op_i(div_op_i), .operand_a_i(a), .operand_b_i(b),
        .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        if (valid_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_valid: got valid_o=1 result=%h expected no pulse", result_o);
            end else check("sb_result", result_o, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int k;
        bit busy_ok, seen;
        div_op_i = v.op;
        a = v.a;
        b = v.b;
        start_i = 1'b1;
        sb.push_back(v.res);
        next_cycle();
        start_i = 1'b0;
        k = 1;
        busy_ok = 1'b1;
        seen = 1'b0;
        while (k <= 40 && !seen) begin
            #1;
            if (!busy_o) busy_ok = 1'b0;
            if (valid_o) seen = 1'b1;
            else begin
                next_cycle();
                k++;
            end
        end
        check({name, "_latency"}, seen ? k : -1, v.lat);
        check({name, "_busy"}, busy_ok, 1);
        if (!seen) sb.delete();
        next_cycle();
        #1;
        check({name, "_idle_after"}, {busy_o, valid_o}, 0);
    endtask

    task automatic hold_run(input logic [31:0] a2, input logic [31:0] b2, input logic [31:0] exp2, input string name);
        int errs;
        errs = 0;
        div_op_i = DIVU;
        a = 32'hFFFFFFFF;
        b = 32'd1;
        start_i = 1'b1;
        sb.push_back(32'hFFFFFFFF);
        for (int k = 1; k <= 67; k++) begin
            next_cycle();
            if (k == 5) begin
                a = a2;
                b = b2;
            end
            if (k == 34) sb.push_back(exp2);
            #1;
            if (valid_o !== (k == 33 || k == 67)) errs++;
        end
        start_i = 1'b0;
        check({name, "_valid_cycles"}, errs, 0);
        next_cycle();
        #1;
        check({name, "_idle_after"}, busy_o, 0);
    endtask

    initial begin
        vecs[0]  = '{DIVU, 32'd100, 32'd7, 32'd14, 33};
        vecs[1]  = '{REMU, 32'd100, 32'd7, 32'd2, 33};
        vecs[2]  = '{DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33};
        vecs[3]  = '{REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33};
        vecs[4]  = '{REM, 32'd7, 32'hFFFFFFFE, 32'd1, 33};
        vecs[5]  = '{DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1};
        vecs[6]  = '{REMU, 32'd5, 32'd0, 32'd5, 1};
        vecs[7]  = '{DIVU, 32'd0, 32'd0, 32'hFFFFFFFF, 1};
        vecs[8]  = '{REM, 32'd5, 32'd0, 32'd5, 1};
        vecs[9]  = '{DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[10] = '{REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1};
        vecs[11] = '{DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33};
        vecs[12] = '{REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        vecs[13] = '{DIV, 32'h80000000, 32'd2, 32'hC0000000, 33};
        vecs[14] = '{DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33};
        vecs[15] = '{REM, 32'd100, 32'hFFFFFFF9, 32'd2, 33};
        vecs[16] = '{DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 33};
        vecs[17] = '{REM, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 33};
        vecs[18] = '{DIVU, 32'd7, 32'd100, 32'd0, 33};
        vecs[19] = '{REMU, 32'd7, 32'd100, 32'd7, 33};
        vecs[20] = '{DIVU, 32'hDEADBEEF, 32'h10, 32'h0DEADBEE, 33};
        vecs[21] = '{REMU, 32'hDEADBEEF, 32'h10, 32'hF, 33};
        rst_ni = 1'b0;
        start_i = 1'b0;
        kill_i = 1'b0;
        div_op_i = DIVU;
        a = '0;
        b = '0;
        @(posedge clk);
        #1;
        next_cycle();
        check("reset_outputs", {busy_o, valid_o, result_o}, 0);
        rst_ni = 1'b1;
        next_cycle();
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
        div_op_i = DIVU;
        a = 32'd1000;
        b = 32'd3;
        start_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        repeat (9) next_cycle();
        kill_i = 1'b1;
        #1;
        check("kill_busy_c10", busy_o, 1);
        next_cycle();
        kill_i = 1'b0;
        #1;
        check("kill_busy_c11", busy_o, 0);
        check("kill_result_held", result_o, 32'hF);
        run_vec('{DIVU, 32'd9, 32'd3, 32'd3, 33}, "after_kill");
        div_op_i = DIVU;
        a = 32'd1000;
        b = 32'd3;
        start_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        repeat (9) next_cycle();
        rst_ni = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
        #1;
        check("midreset_outputs", {busy_o, valid_o, result_o}, 0);
        div_op_i = DIVU;
        a = 32'd8;
        b = 32'd2;
        start_i = 1'b1;
        kill_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        kill_i = 1'b0;
        #1;
        check("kill_beats_start", busy_o, 0);
        repeat (36) next_cycle();
        a = 32'd10;
        b = 32'd2;
        start_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        repeat (32) next_cycle();
        kill_i = 1'b1;
        #1;
        check("kill_done_valid", valid_o, 0);
        check("kill_done_result", result_o, 32'd5);
        next_cycle();
        kill_i = 1'b0;
        #1;
        check("kill_done_idle", busy_o, 0);
        hold_run(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, "b2b_same");
        hold_run(32'd12, 32'd4, 32'd3, "b2b_change");
        repeat (3) next_cycle();
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
